display_encoder: RTL
====================

Name: display_encoder

Overview:
- Reader side of the multiplexed 7-segment display bus. Samples the active-low segment lines and the active-low digit-select lines.
- Converts each stable segment pattern back to its hex nibble, assembles one full scan frame into a DIGITS-wide hex word, and flags patterns that do not decode.
- Used for self-check and loopback of display paths driven by the hex-to-segment decoder.

Parameters:
DIGITS, 4, number of multiplexed digits (anode lines); legal range 2..8
STABLE_CYCLES, 4, consecutive identical synced samples required before a digit is accepted; legal range 2..255

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
segmentos  input  7  segment lines, active-low (0 = lit); bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g
anodos  input  DIGITS  digit select, active-low one-hot; bit k selects digit k; digit 0 = least significant nibble
saida  output  4*DIGITS  last published frame; nibble k = digit k
valido  output  1  one-cycle pulse when saida is updated
erro  output  1  set with each publish if any digit in that frame did not decode; held until the next publish

Behaviour:
- Reset (synchronous, active-high): saida=0, valido=0, erro=0. Sync stages, stability counter, shadow nibbles, seen mask and frame-error flag are cleared. State = WAIT_D0.
- Input sync: segmentos and anodos pass through 2 flop stages. All logic below uses the synced values.
- Selection: a sample is selecting when exactly one anodos bit is 0. Zero or multiple low bits means blank: counter cleared, nothing captured.
- Stability: the counter increments while the (anodos, segmentos) pair is identical to the previous synced sample and selecting. Otherwise it is cleared (reloads to 1 on a new selecting pair). The counter saturates.
- Accept: occurs on the edge where the counter reaches STABLE_CYCLES. Accept happens once per stable run and does not repeat until the pair changes.
- Decode table (segmentos to nibble), applied at accept:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7
  - 0000000=8, 0001100=9, 0001000=A, 1100000=b, 1110010=c, 1000010=d, 0110000=E, 0111000=F
  - Any other pattern, including 1111111 (all off), is invalid: the nibble is stored as 0 and the frame-error flag is set.
- FSM:
  - WAIT_D0: ignore accepts of digits other than 0. On accept of digit 0: store shadow[0], seen=1 (bit 0 only), frame-error flag = invalid(digit 0), go to CAPTURE.
  - CAPTURE:
    - On accept of digit k≠0: shadow[k] is stored and seen[k] set. A repeat of k overwrites shadow[k]. The frame-error flag ORs in invalid(k).
    - On accept of digit 0 before seen is all ones: the frame restarts exactly as in WAIT_D0 (partial frame discarded, no publish).
    - When seen becomes all ones, go to PUBLISH on the next edge.
  - PUBLISH (1 cycle): saida = shadow, erro = frame-error flag, valido = 1, then go to WAIT_D0.
- valido is high for exactly one cycle per published frame. saida and erro change only in PUBLISH.
- Minimum latency, from the input change of the last digit to valido high: 2 (sync) + STABLE_CYCLES + 1 cycles.
- Scan order does not matter except that digit 0 opens a frame.
- Reset asserted mid-frame discards the partial frame. saida is cleared to 0 and no valido is issued.

Optional Feature:
- Macro: DISPLAY_ENCODER_CHANGE_ONLY_EN.
- Defined: in PUBLISH, valido pulses only if the new {erro, saida} differs from the currently held value. saida and erro are still written. After reset, the first frame always pulses.
- Undefined: every completed frame pulses valido.

Test Plan:
- Reset held 3 cycles with random inputs -> saida=0, valido=0, erro=0. No pulse for 10 cycles after release with all anodos=1111.
- Scan 4 digits, 8 cycles each, patterns for 3,2,1,0 on digits 3..0 (digit 0 first) -> single valido pulse, saida=16'h3210, erro=0, latency per the formula above.
- Digit 2 pattern 1111111 in the frame 'A','8','F','1' -> saida=16'hA0F1 (nibble 2 stored as 0), erro=1. Next clean frame 16'h1234 -> erro=0.
- Each digit held only STABLE_CYCLES-1 cycles -> no accept, no valido. Two anodos low simultaneously for 20 cycles -> no accept.
- Digits 0 and 1 captured, then digit 0 reappears with '7', then digits 1..3 = '6','5','4' -> one pulse, saida=16'h4567, stale nibble discarded.
- With DISPLAY_ENCODER_CHANGE_ONLY_EN, three identical frames 16'hBEEF -> exactly one valido pulse. Without the macro -> three pulses.

Source files
------------

// File: rtl/display_encoder.sv
// display_encoder: reader side of a multiplexed 7-segment display bus.
// Samples the active-low segment and digit-select lines and decodes each stable
// segment pattern back to a hex nibble. One full scan frame is assembled into a
// DIGITS-wide hex word and published. A pattern that does not decode stores a
// zero nibble and marks the frame as erroneous.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   segmentos  in   [6:0] segments a..g on bits 6..0, active-low
//   anodos     in   [DIGITS-1:0] digit select, active-low one-hot, bit k = digit k
//   saida      out  [4*DIGITS-1:0] last published frame, nibble k = digit k
//   valido     out  one-cycle pulse when saida is updated
//   erro       out  frame contained an undecodable digit, held until next publish
//
// Optional build macro DISPLAY_ENCODER_CHANGE_ONLY_EN: valido pulses only when
// the published {erro, saida} differs from the held value. The first frame
// after reset always pulses.
module display_encoder #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [6:0]            segmentos,
  input  logic [DIGITS-1:0]     anodos,
  output logic [4*DIGITS-1:0]   saida,
  output logic                  valido,
  output logic                  erro
);

  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam int unsigned OUT_W = 4 * DIGITS;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {WAIT_D0, CAPTURE, PUBLISH} state_e;

  // Segment pattern to {invalid, nibble}.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b0000001: r = 5'h00;
      7'b1001111: r = 5'h01;
      7'b0010010: r = 5'h02;
      7'b0000110: r = 5'h03;
      7'b1001100: r = 5'h04;
      7'b0100100: r = 5'h05;
      7'b0100000: r = 5'h06;
      7'b0001111: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0001100: r = 5'h09;
      7'b0001000: r = 5'h0A;
      7'b1100000: r = 5'h0B;
      7'b1110010: r = 5'h0C;
      7'b1000010: r = 5'h0D;
      7'b0110000: r = 5'h0E;
      7'b0111000: r = 5'h0F;
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [6:0]         seg_s1_q, seg_s2_q, seg_prev_q;
  logic [DIGITS-1:0]  an_s1_q, an_s2_q, an_prev_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   shadow_q, shadow_d;
  logic [DIGITS-1:0]  seen_q, seen_d;
  logic               ferr_q, ferr_d;
  logic [OUT_W-1:0]   saida_q, saida_d;
  logic               valido_q, valido_d;
  logic               erro_q, erro_d;
`ifdef DISPLAY_ENCODER_CHANGE_ONLY_EN
  logic               first_q, first_d;
`endif

  logic [DIGITS-1:0]  an_n;
  logic               sel, same, accept;
  logic [IDX_W-1:0]   sel_idx;
  logic [4:0]         dec;

  // Selection, stability counting and accept detection on synced samples.
  always_comb begin
    an_n    = ~an_s2_q;
    sel     = (an_n != '0) && ((an_n & (an_n - DIGITS'(1))) == '0);
    same    = (an_s2_q == an_prev_q) && (seg_s2_q == seg_prev_q);
    sel_idx = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (an_n[i]) sel_idx = IDX_W'(i);
    end
    dec = decode_seg(seg_s2_q);

    if (!sel) begin
      cnt_d = '0;
    end else if (same) begin
      // Saturates at STABLE_CYCLES so a long hold accepts only once.
      cnt_d = (cnt_q < CNT_W'(STABLE_CYCLES)) ? cnt_q + CNT_W'(1) : cnt_q;
    end else begin
      cnt_d = CNT_W'(1);
    end
    accept = sel && same && (cnt_q == CNT_W'(STABLE_CYCLES - 1));
  end

  // Frame assembly FSM: digit 0 opens a frame, all digits seen closes it.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    seen_d   = seen_q;
    ferr_d   = ferr_q;
    saida_d  = saida_q;
    erro_d   = erro_q;
    valido_d = 1'b0;
`ifdef DISPLAY_ENCODER_CHANGE_ONLY_EN
    first_d  = first_q;
`endif

    case (state_q)
      WAIT_D0: begin
        if (accept && sel_idx == '0) begin
          shadow_d = OUT_W'(dec[3:0]);
          seen_d   = DIGITS'(1);
          ferr_d   = dec[4];
          state_d  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (accept) begin
          if (sel_idx == '0) begin
            // Digit 0 again: drop the partial frame and start over.
            shadow_d = OUT_W'(dec[3:0]);
            seen_d   = DIGITS'(1);
            ferr_d   = dec[4];
          end else begin
            shadow_d[{sel_idx, 2'b00} +: 4] = dec[3:0];
            seen_d[sel_idx]                 = 1'b1;
            ferr_d                          = ferr_q | dec[4];
            if (&seen_d) state_d = PUBLISH;
          end
        end
      end
      PUBLISH: begin
        saida_d = shadow_q;
        erro_d  = ferr_q;
`ifdef DISPLAY_ENCODER_CHANGE_ONLY_EN
        valido_d = first_q || ({ferr_q, shadow_q} != {erro_q, saida_q});
        first_d  = 1'b0;
`else
        valido_d = 1'b1;
`endif
        state_d = WAIT_D0;
      end
      default: state_d = WAIT_D0;
    endcase
  end

  // State, sync stages and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= WAIT_D0;
      seg_s1_q   <= '0;
      seg_s2_q   <= '0;
      seg_prev_q <= '0;
      an_s1_q    <= '0;
      an_s2_q    <= '0;
      an_prev_q  <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      seen_q     <= '0;
      ferr_q     <= 1'b0;
      saida_q    <= '0;
      valido_q   <= 1'b0;
      erro_q     <= 1'b0;
`ifdef DISPLAY_ENCODER_CHANGE_ONLY_EN
      first_q    <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      seg_s1_q   <= segmentos;
      seg_s2_q   <= seg_s1_q;
      seg_prev_q <= seg_s2_q;
      an_s1_q    <= anodos;
      an_s2_q    <= an_s1_q;
      an_prev_q  <= an_s2_q;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      seen_q     <= seen_d;
      ferr_q     <= ferr_d;
      saida_q    <= saida_d;
      valido_q   <= valido_d;
      erro_q     <= erro_d;
`ifdef DISPLAY_ENCODER_CHANGE_ONLY_EN
      first_q    <= first_d;
`endif
    end
  end

  assign saida  = saida_q;
  assign valido = valido_q;
  assign erro   = erro_q;

endmodule
